multiply_scheduler: RTL
=======================

Name: multiply_scheduler

Overview:
- Round-robin scheduler that shares one serial shift-and-add Multiplier between R requesters.
- Accepts operand pairs over a valid/ready handshake and sequences the Multiplier's start/finished protocol.
- Returns each 2N-bit product on a single response channel, tagged with the requester index.
- Sits between processing lanes and the one multiplier instance, so the lanes need no multipliers of their own.

Parameters:
- N, 8, operand width; passed to the internal Multiplier instance.
- R, 4, number of requesters, R >= 2.
- W, $clog2(R), requester ID width (localparam).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset; also drives the internal Multiplier reset
- i_req_valid  in  R  per-requester request valid
- o_req_ready  out  R  per-requester grant/accept; at most one bit high per cycle
- i_req_multiplicand  in  R*N  packed; requester k occupies bits [k*N +: N]
- i_req_multiplier  in  R*N  packed, same layout
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumer ready
- o_rsp_id  out  W  index of the requester that owns the response
- o_rsp_product  out  2N  product = multiplicand * multiplier, unsigned
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Internal Multiplier protocol:
  - Drive one-cycle start pulse with stable operands.
  - Multiplier asserts finished exactly N cycles after the start cycle.
  - Product is valid only in the finished cycle.
  - Scheduler never pulses start while an operation is in flight.
- State machine IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any i_req_valid is set, grant the first valid requester at or after rr_ptr, searching upward mod R.
  - Assert o_req_ready[g] combinationally that cycle only.
  - Latch both operands and g into internal registers.
  - Set rr_ptr <= (g+1) mod R; go to START.
  - No valid requests: stay in IDLE, o_req_ready = 0.
- START: drive Multiplier start = 1 for exactly one cycle with latched operands; go to WAIT.
- WAIT: hold until Multiplier finished = 1; on that edge capture the product into rsp_product_q; go to RESP.
- RESP:
  - o_rsp_valid = 1; o_rsp_id and o_rsp_product stay stable until i_rsp_ready = 1.
  - On valid & ready, go to IDLE.
  - No grant is issued in the handshake cycle itself.
- Latency: grant in cycle T -> start at T+1 -> finished at T+1+N -> o_rsp_valid from T+N+2.
  - Minimum issue interval is N+3 cycles per operation.
- Requesters hold valid and operands stable until granted.
  - Dropping valid before grant is legal: the request is withdrawn, nothing is latched.
- Operand registers and ID are captured at grant, so requester inputs may change from T+1.
- Arithmetic: unsigned, full 2N-bit result; no overflow is possible.
- Fairness: pointer rotation guarantees each continuously valid requester a grant within R operations.
- Reset values: state = IDLE, rr_ptr = 0, o_req_ready = 0, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_product = 0, o_busy = 0.
- Reset mid-operation (any state):
  - The in-flight operation is discarded, with no response.
  - The Multiplier is reset in the same cycle.
  - The first grant after reset goes to the lowest-index valid requester.
- Simultaneous i_rsp_ready with no o_rsp_valid: ignored.
- i_req_valid changes during START/WAIT/RESP: ignored; o_req_ready stays 0.

Optional Feature:
- Macro MULT_SCHED_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted request has multiplicand == 0 or multiplier == 0, skip START/WAIT.
  - Go directly to RESP with o_rsp_product = 0; o_rsp_valid rises at T+1.
  - The Multiplier is not started. rr_ptr advances as normal.
- Not defined: zero operands follow the normal START/WAIT path and produce 0 at T+N+2.
- Bypass logic and its compare are absent from the netlist when the macro is undefined.

Test Plan:
- Single request, N=8, R=4: requester 2 sends 13 x 11, i_rsp_ready = 1 -> grant at T; o_rsp_valid at T+10 with id 2, product 143 (0x008F); o_busy low at T+11.
- Max operands: requester 0 sends 255 x 255 -> product 65025 (0xFE01), id 0.
- All four requesters valid continuously, distinct operands (k+1) x 3 -> grants in order 0,1,2,3,0; products 3, 6, 9, 12, 3 with matching IDs; never two o_req_ready bits high.
- Backpressure: hold i_rsp_ready = 0 for 5 cycles during RESP while requester 1 is valid -> response id/product stable all 5 cycles; no grant to requester 1 until the cycle after the handshake.
- Reset asserted during WAIT (cycle T+4) -> next cycle all outputs 0, state IDLE, no response for the aborted op; a subsequent request from requester 3 (with 0 also valid) is granted to 0 first.
- Zero operand, 0 x 200:
  - With MULT_SCHED_ZERO_BYPASS_EN: o_rsp_valid at T+1, product 0, Multiplier start never pulsed.
  - Without the macro: o_rsp_valid at T+10, product 0.

Source files
------------

// File: rtl/multiply_scheduler.sv
// rtl/multiply_scheduler.sv - round-robin scheduler sharing one serial shift-and-add multiplier (option: MULT_SCHED_ZERO_BYPASS_EN)

module mult_shift_add #(
    parameter int N = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic           o_finished,
    output logic [2*N-1:0] o_product
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           run_q, run_d;
    logic [2*N-1:0] sum;

    // The final partial product is added combinationally so finished lands N cycles after start.
    always_comb begin
        sum        = acc_q + ({2*N{mplier_q[0]}} & mcand_q);
        o_product  = sum;
        o_finished = run_q && (cnt_q == CW'(1));
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        if (i_start) begin
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, i_multiplicand};
            mplier_d = i_multiplier;
            cnt_d    = CW'(N);
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            run_d    = (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

module multiply_scheduler #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int W = $clog2(R)
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [R-1:0]   i_req_valid,
    output logic [R-1:0]   o_req_ready,
    input  logic [R*N-1:0] i_req_multiplicand,
    input  logic [R*N-1:0] i_req_multiplier,
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [W-1:0]   o_rsp_id,
    output logic [2*N-1:0] o_rsp_product,
    output logic           o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   id_q, id_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] rsp_product_q, rsp_product_d;

    logic [N-1:0]   req_a [R];
    logic [N-1:0]   req_b [R];
    logic           grant_valid;
    logic [W-1:0]   grant_idx;
    logic [W-1:0]   cand;
    logic           mult_start;
    logic           mult_finished;
    logic [2*N-1:0] mult_product;

    mult_shift_add #(.N(N)) u_mult (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (mult_start),
        .i_multiplicand (mcand_q),
        .i_multiplier   (mplier_q),
        .o_finished     (mult_finished),
        .o_product      (mult_product)
    );

    // First valid requester at or after rr_ptr, wrapping modulo R.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < R; i++) begin
            req_a[i] = i_req_multiplicand[i*N +: N];
            req_b[i] = i_req_multiplier[i*N +: N];
            cand     = W'((int'(rr_ptr_q) + i) % R);
            if (!grant_valid && i_req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        rsp_product_d = rsp_product_q;
        o_req_ready   = '0;
        mult_start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid && !i_reset) begin
                    o_req_ready[grant_idx] = 1'b1;
                    id_d     = grant_idx;
                    mcand_d  = req_a[grant_idx];
                    mplier_d = req_b[grant_idx];
                    rr_ptr_d = (grant_idx == W'(R - 1)) ? '0 : grant_idx + W'(1);
`ifdef MULT_SCHED_ZERO_BYPASS_EN
                    if ((req_a[grant_idx] == '0) || (req_b[grant_idx] == '0)) begin
                        rsp_product_d = '0;
                        state_d       = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
`else
                    state_d = S_START;
`endif
                end
            end
            S_START: begin
                mult_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mult_finished) begin
                    rsp_product_d = mult_product;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    assign o_rsp_valid   = (state_q == S_RESP);
    assign o_busy        = (state_q != S_IDLE);
    assign o_rsp_id      = id_q;
    assign o_rsp_product = rsp_product_q;
endmodule
